// File: rtl/frame_word_packer_if.sv
// frame_word_packer_if: ingress byte stream, FWFT word egress and status bundle for frame_word_packer
// Signals: rxd/rxd_v (byte in), out_data/out_keep/out_sof/out_eof/out_valid/out_ready (word out),
//          frame_cnt/drop_cnt/busy (status). master = producer/consumer side, slave = packer side.
interface frame_word_packer_if;
    logic [7:0]  rxd;
    logic        rxd_v;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_sof;
    logic        out_eof;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        busy;
    modport master (
        output rxd, rxd_v, out_ready,
        input  out_data, out_keep, out_sof, out_eof, out_valid, frame_cnt, drop_cnt, busy
    );
    modport slave (
        input  rxd, rxd_v, out_ready,
        output out_data, out_keep, out_sof, out_eof, out_valid, frame_cnt, drop_cnt, busy
    );
endinterface

// File: rtl/frame_word_packer.sv
// frame_word_packer: packs each rxd_v byte run little-endian into 32-bit words and releases only legal frames
// Ports: clk, rst (synchronous, active high); bus (slave modport): rxd/rxd_v ingress bytes,
//        out_* first-word-fall-through word egress, frame_cnt (wraps), drop_cnt (saturates), busy.
// Build option: define FRAME_SUM_EN to check the last byte of each frame as the mod-256 sum of the others.
module frame_word_packer #(
    parameter int FIFO_DEPTH = 64,
    parameter int MIN_LEN    = 4,
    parameter int MAX_LEN    = 255
) (
    input logic clk,
    input logic rst,
    frame_word_packer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    // entry layout: {data[31:0], keep[3:0], sof, eof}
    logic [37:0]   mem_q [FIFO_DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    lane_q, lane_d;
    logic [23:0]   word_q, word_d;
    logic [LW-1:0] len_q, len_d;
    logic          first_q, first_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          valid, full, bad_sum, we;
    logic [37:0]   rd_e, wdata;
    logic [AW-1:0] waddr, prev_a;
    logic [LW-1:0] len_inc;
    logic [15:0]   drop_inc;
    logic [3:0]    keep;

    assign valid    = rd_ptr_q != cmt_ptr_q;
    assign rd_e     = mem_q[rd_ptr_q[AW-1:0]];
    assign prev_a   = wr_ptr_q[AW-1:0] - AW'(1);
    assign full     = (wr_ptr_q - rd_ptr_q) == (AW+1)'(FIFO_DEPTH);
    assign len_inc  = (len_q == LW'(MAX_LEN + 1)) ? len_q : len_q + LW'(1);
    assign drop_inc = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    assign keep     = (lane_q == 2'd1) ? 4'h1 : (lane_q == 2'd2) ? 4'h3 : 4'h7;

    // memory contents are never reset, so the egress bus is forced to zero when nothing is committed
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? rd_e[37:6] : 32'h0;
    assign bus.out_keep  = valid ? rd_e[5:2] : 4'h0;
    assign bus.out_sof   = valid & rd_e[1];
    assign bus.out_eof   = valid & rd_e[0];
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.busy      = state_q != IDLE;

`ifdef FRAME_SUM_EN
    // sum_q trails one byte behind so that at end of frame it excludes the checksum byte held in last_q
    logic [7:0] sum_q, last_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 8'h00;
            last_q <= 8'h00;
        end else if (bus.rxd_v) begin
            sum_q  <= (state_q == IDLE) ? 8'h00 : sum_q + last_q;
            last_q <= bus.rxd;
        end
    end
    assign bad_sum = sum_q != last_q;
`else
    assign bad_sum = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        rd_ptr_d    = (valid && bus.out_ready) ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        lane_d      = lane_q;
        word_d      = word_q;
        len_d       = len_q;
        first_d     = first_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        we          = 1'b0;
        waddr       = wr_ptr_q[AW-1:0];
        wdata       = {bus.rxd, word_q, 4'hF, first_q, 1'b0};
        case (state_q)
            IDLE: begin
                if (bus.rxd_v) begin
                    word_d   = {16'h0, bus.rxd};
                    lane_d   = 2'd1;
                    len_d    = LW'(1);
                    first_d  = 1'b1;
                    wr_ptr_d = cmt_ptr_q;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (bus.rxd_v) begin
                    len_d = len_inc;
                    if (lane_q == 2'd3) begin
                        we       = !full;
                        wr_ptr_d = full ? wr_ptr_q : wr_ptr_q + (AW+1)'(1);
                        first_d  = 1'b0;
                        word_d   = 24'h0;
                        lane_d   = 2'd0;
                    end else begin
                        word_d = (lane_q == 2'd0) ? {16'h0, bus.rxd} :
                                 (lane_q == 2'd1) ? {8'h0, bus.rxd, word_q[7:0]} : {bus.rxd, word_q[15:0]};
                        lane_d = lane_q + 2'd1;
                    end
                    if ((lane_q == 2'd3 && full) || len_inc > LW'(MAX_LEN))
                        state_d = DROP;
                end else if (len_q < LW'(MIN_LEN) || (lane_q != 2'd0 && full) || bad_sum) begin
                    wr_ptr_d   = cmt_ptr_q;
                    drop_cnt_d = drop_inc;
                    state_d    = IDLE;
                end else begin
                    we = 1'b1;
                    if (lane_q != 2'd0) begin
                        wdata     = {8'h0, word_q, keep, first_q, 1'b1};
                        wr_ptr_d  = wr_ptr_q + (AW+1)'(1);
                        cmt_ptr_d = wr_ptr_q + (AW+1)'(1);
                    end else begin
                        // frame ended on a word boundary: mark the already written last word as eof
                        waddr     = prev_a;
                        wdata     = {mem_q[prev_a][37:1], 1'b1};
                        cmt_ptr_d = wr_ptr_q;
                    end
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            DROP: begin
                if (!bus.rxd_v) begin
                    wr_ptr_d   = cmt_ptr_q;
                    drop_cnt_d = drop_inc;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            lane_q      <= 2'd0;
            word_q      <= 24'h0;
            len_q       <= '0;
            first_q     <= 1'b0;
            frame_cnt_q <= 32'h0;
            drop_cnt_q  <= 16'h0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            len_q       <= len_d;
            first_q     <= first_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem_q[waddr] <= wdata;
    end
endmodule
